// File: rtl/serial_8bit_subtractor.sv
// serial_8bit_subtractor: bit-serial 8-bit subtractor, LSB first.
// One accepted start produces diff = a - b - bin (mod 256), the unsigned
// borrow-out and the signed overflow flag, with a done pulse 8 edges later.
module serial_8bit_subtractor (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       bin,
   output logic [7:0] diff,
   output logic       bout,
   output logic       ovf,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q,   cnt_d;
   logic [7:0] a_q,     a_d;
   logic [7:0] b_q,     b_d;
   logic       br_q,    br_d;
   logic [7:0] diff_q,  diff_d;
   logic       bout_q,  bout_d;
   logic       ovf_q,   ovf_d;
   logic       busy_q,  busy_d;
   logic       done_q,  done_d;

   // Per-cycle bit slice of the serial datapath.
   logic bit_a;
   logic bit_b;
   logic bit_d;
   logic br_next;

   // State and datapath registers; synchronous reset clears everything.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling the old
      // values of its neighbours, regardless of statement order.
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         a_q     <= 8'd0;
         b_q     <= 8'd0;
         br_q    <= 1'b0;
         diff_q  <= 8'd0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state, serial full-subtractor step and registered output flags.
   always_comb begin
      // NOTE: every signal gets a hold/default value first so that no path
      // through the case leaves it unassigned (which would infer a latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;

      bit_a   = a_q[cnt_q];
      bit_b   = b_q[cnt_q];
      bit_d   = bit_a ^ bit_b ^ br_q;
      br_next = (~bit_a & bit_b) | (~bit_a & br_q) | (bit_b & br_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               cnt_d   = 3'd0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            diff_d[cnt_q] = bit_d;
            br_d          = br_next;
            cnt_d         = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               // Bit 7 of the result is bit_d itself this cycle.
               bout_d  = br_next;
               ovf_d   = (a_q[7] ^ b_q[7]) & (a_q[7] ^ bit_d);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Flags are registered so they line up with the state they describe.
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_serial_8bit_subtractor.sv
// tb_serial_8bit_subtractor: directed and swept checks of the serial
// subtractor against an arithmetic reference model.
module tb_serial_8bit_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic [7:0] diff;
   logic       bout;
   logic       ovf;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   serial_8bit_subtractor dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result {ovf, bout, diff} from plain integer arithmetic.
   function automatic logic [9:0] ref_result(input logic [7:0] ra, input logic [7:0] rb, input logic rbin);
      int u;
      int s;
      logic [7:0] rd;
      logic       rbo;
      logic       rov;
      u   = int'(ra) - int'(rb) - int'(rbin);
      s   = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
      rd  = u[7:0];
      rbo = (u < 0);
      rov = (s > 127) || (s < -128);
      return {rov, rbo, rd};
   endfunction

   // Model: an accepted operation occupies 9 further cycles (8 RUN + DONE).
   int         rem = 0;
   logic [9:0] op_res = '0;
   logic [7:0] exp_diff = '0;
   logic       exp_bout = 1'b0;
   logic       exp_ovf = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         rem      <= 0;
         exp_diff <= '0;
         exp_bout <= 1'b0;
         exp_ovf  <= 1'b0;
      end else if (rem == 0) begin
         if (start) begin
            rem    <= 9;
            op_res <= ref_result(a, b, bin);
         end
      end else begin
         rem <= rem - 1;
         if (rem == 2) begin
            exp_diff <= op_res[7:0];
            exp_bout <= op_res[8];
            exp_ovf  <= op_res[9];
         end
      end
   end

   // Compare process: checks outputs against the model every cycle.
   logic chk_en   = 1'b0;
   logic sweep_en = 1'b0;
   int   cyc      = 0;
   int   last_done = 0;
   logic have_last = 1'b0;
   int   idle_cnt  = 0;
   int   done_count = 0;

   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         check("busy", 32'(busy), 32'(rem != 0));
         check("done", 32'(done), 32'(rem == 1));
         if (rem <= 1) begin
            check("diff", 32'(diff), 32'(exp_diff));
            check("bout", 32'(bout), 32'(exp_bout));
            check("ovf",  32'(ovf),  32'(exp_ovf));
         end
         if (!busy) idle_cnt++;
         if (!sweep_en) have_last = 1'b0;
         if (done) begin
            done_count++;
            if (sweep_en && have_last) begin
               check("done_spacing", 32'(cyc - last_done), 32'd10);
               check("idle_gap", 32'(idle_cnt), 32'd1);
            end
            last_done = cyc;
            have_last = sweep_en;
            idle_cnt  = 0;
         end
      end
   end

   // Waits (bounded) for done; cnt is negedges after the accepting edge.
   task automatic wait_done(output int cnt);
      cnt = 0;
      while (cnt < 20) begin
         @(negedge clk);
         cnt++;
         if (done) return;
      end
      check("done_timeout", 32'(cnt), 32'd8);
   endtask

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input logic [7:0] ed, input logic eb, input logic eo);
      int n;
      @(negedge clk);
      a = ta; b = tb; bin = tbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~ta; b = ~tb; bin = ~tbin;
      wait_done(n);
      check("latency", 32'(n), 32'd8);
      check("lit_diff", 32'(diff), 32'(ed));
      check("lit_bout", 32'(bout), 32'(eb));
      check("lit_ovf",  32'(ovf),  32'(eo));
      @(negedge clk);
      check("hold_diff", 32'(diff), 32'(ed));
   endtask

   initial begin
      int n;
      int dc;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      run_op(8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1);

      // Start pulsed during RUN must be ignored.
      @(negedge clk);
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      dc = done_count;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 2;
      while (n < 20 && !done) begin
         @(negedge clk);
         n++;
      end
      check("ign_latency", 32'(n), 32'd8);
      check("ign_diff", 32'(diff), 32'h0F);
      repeat (4) @(negedge clk);
      check("ign_single_done", 32'(done_count - dc), 32'd1);

      // Reset while RUN is processing bit 4.
      @(negedge clk);
      a = 8'h33; b = 8'h11; bin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dc = done_count;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_bout", 32'(bout), 32'd0);
      check("abort_ovf",  32'(ovf),  32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_no_done", 32'(done_count - dc), 32'd0);
      run_op(8'h09, 8'h09, 1'b0, 8'h00, 1'b0, 1'b0);

      // Back-to-back sweep with start held high and inputs churning.
      sweep_en = 1'b1;
      dc = done_count;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 400; i++) begin
         a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      repeat (12) @(negedge clk);
      check("sweep_ops", 32'(done_count - dc), 32'd40);
      sweep_en = 1'b0;
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
